// File: rtl/step_pulse_gen.sv
// STEP/DIR waveform shaper: 2**FIFO_BITS-deep direction FIFO, min STEP high/low and DIR setup timing.
// Latency: step_req at edge E -> STEP rises at E+2 (matching dir). Optional STEP_POSITION_EN adds pos_zero/position.
module step_pulse_gen #(
  parameter int FIFO_BITS = 3,
  parameter int TIME_BITS = 8
`ifdef STEP_POSITION_EN
  , parameter int POS_BITS = 32
`endif
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        step_req,
  input  logic                        dir_in,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [TIME_BITS-1:0]        pulse_width,
  input  logic [TIME_BITS-1:0]        pulse_gap,
  input  logic [TIME_BITS-1:0]        dir_setup,
  input  logic                        clear_overflow,
`ifdef STEP_POSITION_EN
  input  logic                        pos_zero,
  output logic signed [POS_BITS-1:0]  position,
`endif
  output logic                        step_out,
  output logic                        dir_out,
  output logic                        busy,
  output logic                        overflow
);

  localparam int DEPTH = 2 ** FIFO_BITS;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t               r_state;
  logic [TIME_BITS-1:0] r_cnt;
  logic                 r_step;
  logic                 r_dir;
  logic                 r_ovf;
  logic                 r_req;
  logic                 r_req_dir;
  logic [DEPTH-1:0]     r_mem;
  logic [FIFO_BITS:0]   r_wr_ptr;
  logic [FIFO_BITS:0]   r_rd_ptr;

  logic w_empty, w_full, w_head, w_cnt_done, w_start, w_pop, w_push, w_drop;

  // Loaded value is cycles-1 so that a zero setting still gives one cycle.
  function automatic logic [TIME_BITS-1:0] f_load(input logic [TIME_BITS-1:0] v);
    return (v == '0) ? '0 : v - TIME_BITS'(1);
  endfunction

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[FIFO_BITS] != r_rd_ptr[FIFO_BITS]) &&
                      (r_wr_ptr[FIFO_BITS-1:0] == r_rd_ptr[FIFO_BITS-1:0]);
  assign w_head     = r_mem[r_rd_ptr[FIFO_BITS-1:0]];
  assign w_cnt_done = (r_cnt == '0);
  assign w_start    = (r_state == S_IDLE) && enable && !flush && !w_empty;
  assign w_pop      = (w_start && (w_head == r_dir)) ||
                      ((r_state == S_SETUP) && w_cnt_done && enable && !flush);
  assign w_push     = r_req && !flush && (!w_full || w_pop);
  assign w_drop     = r_req && !flush && w_full && !w_pop;

  assign step_out = r_step;
  assign dir_out  = r_dir;
  assign overflow = r_ovf;
  assign busy     = r_req || !w_empty || (r_state != S_IDLE);

  // Requests are registered once before entering the FIFO.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_req_dir <= 1'b0;
    end else begin
      r_req     <= step_req && !flush;
      r_req_dir <= dir_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= r_req_dir;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + (FIFO_BITS+1)'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + (FIFO_BITS+1)'(1);
      end
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_head != r_dir) begin
              r_dir   <= w_head;
              r_cnt   <= f_load(dir_setup);
              r_state <= S_SETUP;
            end else begin
              r_step  <= 1'b1;
              r_cnt   <= f_load(pulse_width);
              r_state <= S_HIGH;
            end
          end
        end
        S_SETUP: begin
          if (flush || !enable) begin
            r_state <= S_IDLE;
          end else if (w_cnt_done) begin
            r_step  <= 1'b1;
            r_cnt   <= f_load(pulse_width);
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - TIME_BITS'(1);
          end
        end
        S_HIGH: begin
          if (w_cnt_done) begin
            r_step  <= 1'b0;
            r_cnt   <= f_load(pulse_gap);
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt - TIME_BITS'(1);
          end
        end
        S_LOW: begin
          if (w_cnt_done) r_state <= S_IDLE;
          else            r_cnt   <= r_cnt - TIME_BITS'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STEP_POSITION_EN
  logic signed [POS_BITS-1:0] r_pos;
  logic signed [POS_BITS-1:0] w_pos_step;

  assign w_pos_step = w_head ? {{(POS_BITS-1){1'b0}}, 1'b1} : {POS_BITS{1'b1}};
  assign position   = r_pos;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)         r_pos <= '0;
    else if (pos_zero) r_pos <= w_pop ? w_pos_step : '0;
    else if (w_pop)    r_pos <= r_pos + w_pos_step;
  end
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: directed scenarios plus randomized traffic vs. a pulse-schedule model.
module tb_step_pulse_gen;
  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       step_req = 1'b0;
  logic       dir_in = 1'b0;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] pulse_width = 8'd1;
  logic [7:0] pulse_gap = 8'd1;
  logic [7:0] dir_setup = 8'd1;
  logic       clear_overflow = 1'b0;
  logic       step_out, dir_out, busy, overflow;
`ifdef STEP_POSITION_EN
  logic              pos_zero = 1'b0;
  logic signed [31:0] position;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam int NMAX = 300;
  bit req_a[NMAX];
  bit dir_a[NMAX];
  bit exp_step[NMAX];
  bit exp_dir[NMAX];
  bit tr_step[NMAX];
  bit tr_dir[NMAX];
  bit tr_busy[NMAX];
  int exp_drops;
  int rises[$];

  step_pulse_gen dut (
    .CLK(CLK), .reset(reset), .step_req(step_req), .dir_in(dir_in), .enable(enable),
    .flush(flush), .pulse_width(pulse_width), .pulse_gap(pulse_gap), .dir_setup(dir_setup),
    .clear_overflow(clear_overflow),
`ifdef STEP_POSITION_EN
    .pos_zero(pos_zero), .position(position),
`endif
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; step_req = 1'b0; dir_in = 1'b0; enable = 1'b1; flush = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic set_timing(input int pw, input int gap, input int su);
    pulse_width = 8'(pw); pulse_gap = 8'(gap); dir_setup = 8'(su);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NMAX; k++) begin req_a[k] = 1'b0; dir_a[k] = 1'b0; end
  endtask

  // Inputs for edge k are applied before edge k; outputs after edge k are recorded at the next negedge.
  task automatic run_trace(input int ncyc, input int flush_at, input int en_at);
    rises.delete();
    for (int k = 0; k < ncyc; k++) begin
      step_req = req_a[k]; dir_in = dir_a[k];
      flush = (k == flush_at); enable = (k >= en_at);
      @(posedge CLK);
      @(negedge CLK);
      tr_step[k] = step_out; tr_dir[k] = dir_out; tr_busy[k] = busy;
      if (step_out && (k == 0 || !tr_step[k-1])) rises.push_back(k);
    end
    step_req = 1'b0; flush = 1'b0; enable = 1'b1;
  endtask

  // Pulse schedule: a pulse may be decided once its entry has been queued and the previous
  // pulse plus one idle cycle has elapsed; a direction change delays the rise by the setup time.
  task automatic model_run(input int pw_i, input int gap_i, input int su_i);
    int pw, gap, su, free_at, pop_at, sz, rise;
    bit cur, pop_now;
    bit q[$];
    pw = (pw_i == 0) ? 1 : pw_i; gap = (gap_i == 0) ? 1 : gap_i; su = (su_i == 0) ? 1 : su_i;
    free_at = 0; pop_at = -1; cur = 1'b0; exp_drops = 0;
    for (int k = 0; k < NMAX; k++) exp_step[k] = 1'b0;
    for (int n = 0; n < NMAX; n++) begin
      pop_now = 1'b0;
      if (n == pop_at) begin
        pop_now = 1'b1; pop_at = -1;
      end else if (n >= free_at && q.size() > 0) begin
        if (q[0] == cur) begin pop_now = 1'b1; rise = n; end
        else begin cur = q[0]; pop_at = n + su; rise = n + su; end
        free_at = rise + pw + gap + 1;
        for (int j = rise; j < rise + pw && j < NMAX; j++) exp_step[j] = 1'b1;
      end
      exp_dir[n] = cur;
      sz = q.size();
      if (pop_now) void'(q.pop_front());
      if (n >= 1 && req_a[n-1]) begin
        if (sz < 8 || pop_now) q.push_back(dir_a[n-1]);
        else exp_drops++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (step_out !== 1'b0) begin n_err++; $display("FAIL reset_step got %b exp 0", step_out); end
    n_vec++; if (dir_out  !== 1'b0) begin n_err++; $display("FAIL reset_dir got %b exp 0", dir_out); end
    n_vec++; if (busy     !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_single_step();
    bit es, eb;
    do_reset(); set_timing(3, 2, 4); clear_stim();
    req_a[0] = 1'b1;
    run_trace(12, -1, 0);
    for (int k = 0; k < 12; k++) begin
      es = (k >= 2 && k <= 4);
      n_vec++; if (tr_step[k] !== es) begin n_err++; $display("FAIL single_step edge %0d got %b exp %b", k, tr_step[k], es); end
      if (k >= 1) begin
        eb = (k <= 6);
        n_vec++; if (tr_busy[k] !== eb) begin n_err++; $display("FAIL single_busy edge %0d got %b exp %b", k, tr_busy[k], eb); end
      end
    end
  endtask

  task automatic test_dir_change();
    bit es, ed;
    do_reset(); set_timing(3, 2, 4); clear_stim();
    req_a[0] = 1'b1; dir_a[0] = 1'b1;
    run_trace(16, -1, 0);
    for (int k = 0; k < 16; k++) begin
      ed = (k >= 2); es = (k >= 6 && k <= 8);
      n_vec++; if (tr_dir[k] !== ed) begin n_err++; $display("FAIL dir_change_dir edge %0d got %b exp %b", k, tr_dir[k], ed); end
      n_vec++; if (tr_step[k] !== es) begin n_err++; $display("FAIL dir_change_step edge %0d got %b exp %b", k, tr_step[k], es); end
    end
  endtask

  task automatic test_overflow();
    do_reset(); set_timing(5, 5, 1); clear_stim();
    for (int k = 0; k < 10; k++) req_a[k] = 1'b1;
    run_trace(130, -1, 0);
    n_vec++; if (rises.size() != 9) begin n_err++; $display("FAIL ovf_pulse_count got %0d exp 9", rises.size()); end
    for (int i = 0; i < rises.size() && i < 9; i++) begin
      n_vec++; if (rises[i] != 2 + 11 * i) begin n_err++; $display("FAIL ovf_rise_%0d got %0d exp %0d", i, rises[i], 2 + 11 * i); end
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_end got %b exp 0", busy); end
    clear_overflow = 1'b1; @(posedge CLK); @(negedge CLK); clear_overflow = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_flush();
    do_reset(); set_timing(4, 3, 1); clear_stim();
    for (int k = 0; k < 5; k++) req_a[k] = 1'b1;
    run_trace(40, 11, 0);
    n_vec++; if (rises.size() != 2) begin n_err++; $display("FAIL flush_pulse_count got %0d exp 2", rises.size()); end
    if (rises.size() >= 2) begin
      n_vec++; if (rises[1] != 10) begin n_err++; $display("FAIL flush_rise2 got %0d exp 10", rises[1]); end
    end
    n_vec++; if (tr_step[13] !== 1'b1) begin n_err++; $display("FAIL flush_width got %b exp 1", tr_step[13]); end
    n_vec++; if (tr_step[14] !== 1'b0) begin n_err++; $display("FAIL flush_fall got %b exp 0", tr_step[14]); end
    n_vec++; if (tr_busy[16] !== 1'b1) begin n_err++; $display("FAIL flush_busy_gap got %b exp 1", tr_busy[16]); end
    n_vec++; if (tr_busy[17] !== 1'b0) begin n_err++; $display("FAIL flush_busy_end got %b exp 0", tr_busy[17]); end
  endtask

  task automatic test_enable();
    int exp_r[3] = '{21, 26, 31};
    do_reset(); set_timing(2, 2, 1); clear_stim();
    for (int k = 0; k < 3; k++) req_a[k] = 1'b1;
    run_trace(40, -1, 21);
    n_vec++; if (tr_busy[20] !== 1'b1) begin n_err++; $display("FAIL enable_busy_held got %b exp 1", tr_busy[20]); end
    n_vec++; if (rises.size() != 3) begin n_err++; $display("FAIL enable_pulse_count got %0d exp 3", rises.size()); end
    for (int i = 0; i < rises.size() && i < 3; i++) begin
      n_vec++; if (rises[i] != exp_r[i]) begin n_err++; $display("FAIL enable_rise_%0d got %0d exp %0d", i, rises[i], exp_r[i]); end
    end
  endtask

  task automatic test_random();
    int pw, gap, su;
    for (int it = 0; it < 8; it++) begin
      pw = $urandom_range(0, 4); gap = $urandom_range(0, 3); su = $urandom_range(0, 4);
      do_reset(); set_timing(pw, gap, su); clear_stim();
      for (int k = 0; k < 120; k++) begin
        req_a[k] = ($urandom_range(0, 99) < 35);
        dir_a[k] = 1'($urandom_range(0, 1));
      end
      model_run(pw, gap, su);
      run_trace(NMAX, -1, 0);
      for (int k = 0; k < NMAX; k++) begin
        n_vec++; if (tr_step[k] !== exp_step[k]) begin n_err++; $display("FAIL rand%0d_step edge %0d got %b exp %b", it, k, tr_step[k], exp_step[k]); end
        n_vec++; if (tr_dir[k] !== exp_dir[k]) begin n_err++; $display("FAIL rand%0d_dir edge %0d got %b exp %b", it, k, tr_dir[k], exp_dir[k]); end
      end
      n_vec++; if (overflow !== (exp_drops > 0)) begin n_err++; $display("FAIL rand%0d_ovf got %b exp %b", it, overflow, exp_drops > 0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_busy_end got %b exp 0", it, busy); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int cnt;
    do_reset(); set_timing(10, 2, 1);
    step_req = 1'b1; dir_in = 1'b0;
    repeat (3) @(negedge CLK);
    step_req = 1'b0;
    for (int i = 0; i < 20 && !step_out; i++) @(negedge CLK);
    n_vec++; if (step_out !== 1'b1) begin n_err++; $display("FAIL rst_mid_wait got %b exp 1", step_out); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (step_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_step got %b exp 0", step_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    @(negedge CLK); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin @(negedge CLK); if (step_out) cnt++; end
    n_vec++; if (cnt != 0) begin n_err++; $display("FAIL rst_mid_queue_lost got %0d high cycles exp 0", cnt); end
  endtask

`ifdef STEP_POSITION_EN
  task automatic test_position();
    do_reset(); set_timing(1, 1, 1); clear_stim();
    n_vec++; if (position !== 32'sd0) begin n_err++; $display("FAIL pos_reset got %0d exp 0", position); end
    for (int k = 0; k < 10; k++) begin req_a[k] = 1'b1; dir_a[k] = (k < 4); end
    run_trace(80, -1, 0);
    n_vec++; if (rises.size() != 10) begin n_err++; $display("FAIL pos_pulse_count got %0d exp 10", rises.size()); end
    n_vec++; if (position !== -32'sd2) begin n_err++; $display("FAIL pos_value got %0d exp -2", position); end
    pos_zero = 1'b1; @(posedge CLK); @(negedge CLK); pos_zero = 1'b0;
    n_vec++; if (position !== 32'sd0) begin n_err++; $display("FAIL pos_zero got %0d exp 0", position); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_dir_change();
    test_overflow();
    test_flush();
    test_enable();
    test_random();
    test_reset_mid_pulse();
`ifdef STEP_POSITION_EN
    test_position();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
